x_wrr_arbiter: RTL and testbench

Parametrised weighted round-robin row arbiter for the pixel hierarchy. It is the successor to the single-cycle row round-robin: ROWS-wide, with an ack handshake that holds each grant until the row is consumed, and optional per-row burst weights. It also provides refresh and group-release signalling to the column/group level. It sits between the pixel-row request lines and the event readout path, and drives the encoded row address.

---
 rtl/ebc_arb_pkg.sv | 22 ++
 rtl/rr_prio_enc.sv | 13 +
 rtl/x_wrr_arbiter.sv | 134 +++++++++++++
 tb/tb_x_wrr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ebc_arb_pkg.sv
// Shared types and helpers for the row arbiter: FSM state, default burst
// weight and a one-hot to index converter.
package ebc_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEFAULT_WEIGHT = 1;
   localparam int MAX_ROWS       = 256;

   // Callers zero-extend their one-hot vector to MAX_ROWS bits.
   function automatic int onehot_to_idx(input logic [MAX_ROWS-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_ROWS; i++)
         if (oh[i]) idx = idx | i;
      return idx;
   endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot of the lowest asserted request.
module rr_prio_enc #(
   parameter int ROWS = 8
) (
   input  logic [ROWS-1:0] req,
   output logic [ROWS-1:0] gnt,
   output logic            any
);

   assign gnt = req & (~req + ROWS'(1));
   assign any = |req;

endmodule

// File: rtl/x_wrr_arbiter.sv
// Weighted round-robin row arbiter with ack handshake, refresh and group release.
// Per-row burst weights are honoured only when ARB_WEIGHT_EN is defined.
module x_wrr_arbiter
   import ebc_arb_pkg::*;
#(
   parameter int ROWS     = 8,
   parameter int X_WIDTH  = $clog2(ROWS),
   parameter int WEIGHT_W = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     enable_i,
   input  logic                     refresh_i,
   input  logic [ROWS-1:0]          req_i,
   input  logic [ROWS*WEIGHT_W-1:0] weight_i,
   input  logic                     ack_i,
   output logic [ROWS-1:0]          gnt_o,
   output logic [X_WIDTH-1:0]       xadd_o,
   output logic                     valid_o,
   output logic                     grp_release_o
);

   arb_state_e           state_q, state_d;
   logic [ROWS-1:0]      gnt_q, gnt_d;
   logic [ROWS-1:0]      mask_q, mask_d;
   logic [X_WIDTH-1:0]   xadd_q, xadd_d;
   logic [WEIGHT_W-1:0]  credit_q, credit_d;
   logic                 ref_pend_q, ref_pend_d;
   logic                 grp_rel_q, grp_rel_d;

   logic [ROWS-1:0]      masked_req, masked_oh, raw_oh, win_oh, retire_mask;
   logic                 masked_any, raw_any;
   logic [X_WIDTH-1:0]   win_idx;
   logic [WEIGHT_W-1:0]  load_credit;
   logic [X_WIDTH:0]     shamt;
   logic                 retire;

   assign masked_req = req_i & mask_q;

   rr_prio_enc #(.ROWS(ROWS)) u_enc_masked (
      .req (masked_req),
      .gnt (masked_oh),
      .any (masked_any)
   );

   rr_prio_enc #(.ROWS(ROWS)) u_enc_raw (
      .req (req_i),
      .gnt (raw_oh),
      .any (raw_any)
   );

   // Masked winner first; an empty masked set wraps to the raw requests.
   assign win_oh  = masked_any ? masked_oh : raw_oh;
   assign win_idx = X_WIDTH'(onehot_to_idx(MAX_ROWS'(win_oh)));

`ifdef ARB_WEIGHT_EN
   logic [WEIGHT_W-1:0] win_weight;
   assign win_weight  = weight_i[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
   assign load_credit = (win_weight == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : win_weight;
`else
   logic unused_weight;
   assign unused_weight = ^weight_i;
   assign load_credit   = WEIGHT_W'(DEFAULT_WEIGHT);
`endif

   // Extra bit so retiring the top row shifts the mask out to all zeros.
   assign shamt       = {1'b0, xadd_q} + (X_WIDTH+1)'(1);
   assign retire_mask = (ref_pend_q | refresh_i) ? '1 : ({ROWS{1'b1}} << shamt);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      xadd_d     = xadd_q;
      mask_d     = mask_q;
      credit_d   = credit_q;
      ref_pend_d = ref_pend_q;
      grp_rel_d  = 1'b0;
      retire     = 1'b0;
      case (state_q)
         IDLE: begin
            if (refresh_i) mask_d = '1;
            if (enable_i && raw_any) begin
               state_d  = GRANT;
               gnt_d    = win_oh;
               xadd_d   = win_idx;
               credit_d = load_credit;
            end
         end
         GRANT: begin
            if (refresh_i) ref_pend_d = 1'b1;
            if (ack_i) begin
               credit_d = credit_q - WEIGHT_W'(1);
               retire   = !((credit_q > WEIGHT_W'(1)) && req_i[xadd_q]);
            end else begin
               retire   = !req_i[xadd_q];
            end
            if (retire) begin
               state_d    = IDLE;
               gnt_d      = '0;
               mask_d     = retire_mask;
               ref_pend_d = 1'b0;
               grp_rel_d  = ((req_i & retire_mask) == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         xadd_q     <= '0;
         mask_q     <= '1;
         credit_q   <= '0;
         ref_pend_q <= 1'b0;
         grp_rel_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         xadd_q     <= xadd_d;
         mask_q     <= mask_d;
         credit_q   <= credit_d;
         ref_pend_q <= ref_pend_d;
         grp_rel_q  <= grp_rel_d;
      end
   end

   assign gnt_o         = gnt_q;
   assign xadd_o        = xadd_q;
   assign valid_o       = |gnt_q;
   assign grp_release_o = grp_rel_q;

endmodule

// File: tb/tb_x_wrr_arbiter.sv
// Bench for x_wrr_arbiter: pointer-based round-robin model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_x_wrr_arbiter;

   localparam int ROWS = 8;
   localparam int XW   = 3;
   localparam int WW   = 2;
`ifdef ARB_WEIGHT_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              refresh = 1'b0;
   logic              ack = 1'b0;
   logic [ROWS-1:0]    req = '0;
   logic [ROWS*WW-1:0] weight = '0;
   logic [ROWS-1:0]    gnt;
   logic [XW-1:0]      xadd;
   logic              valid;
   logic              grp;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   x_wrr_arbiter #(.ROWS(ROWS), .X_WIDTH(XW), .WEIGHT_W(WW)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .enable_i      (enable),
      .refresh_i     (refresh),
      .req_i         (req),
      .weight_i      (weight),
      .ack_i         (ack),
      .gnt_o         (gnt),
      .xadd_o        (xadd),
      .valid_o       (valid),
      .grp_release_o (grp)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(name, 32'(valid), 32'd1);
   endtask

   // Model: priority pointer m_ptr means rows >= m_ptr are favoured
   // (0 = everyone, ROWS = nobody, so the search wraps to row 0).
   bit m_started = 1'b0;
   bit m_held = 1'b0, m_rel = 1'b0, m_pend = 1'b0;
   int m_row = 0, m_cred = 0, m_ptr = 0;

   function automatic int pick(input logic [ROWS-1:0] r, input int ptr);
      for (int i = ptr; i < ROWS; i++) if (r[i]) return i;
      for (int i = 0; i < ROWS; i++) if (r[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      int w, c;
      bit ret;
      m_started = 1'b1;
      if (reset) begin
         m_held = 1'b0; m_rel = 1'b0; m_pend = 1'b0;
         m_row = 0; m_cred = 0; m_ptr = 0;
      end else if (!m_held) begin
         m_rel = 1'b0;
         if (enable && req != '0) begin
            w = pick(req, m_ptr);
            c = int'(weight[w*WW +: WW]);
            m_held = 1'b1;
            m_row  = w;
            m_cred = (WEN && c > 0) ? c : 1;
         end
         if (refresh) m_ptr = 0;
      end else begin
         m_rel = 1'b0;
         ret = 1'b0;
         if (ack) begin
            if (m_cred > 1 && req[m_row]) m_cred = m_cred - 1;
            else ret = 1'b1;
         end else if (!req[m_row]) begin
            ret = 1'b1;
         end
         if (refresh) m_pend = 1'b1;
         if (ret) begin
            m_held = 1'b0;
            m_ptr  = m_pend ? 0 : m_row + 1;
            m_pend = 1'b0;
            m_rel  = 1'b1;
            for (int i = m_ptr; i < ROWS; i++) if (req[i]) m_rel = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("model_gnt",   32'(gnt),   m_held ? (32'd1 << m_row) : 32'd0);
         chk("model_xadd",  32'(xadd),  32'(m_row));
         chk("model_valid", 32'(valid), 32'(m_held));
         chk("model_grp",   32'(grp),   32'(m_rel));
      end
   end

   initial begin
      bit exp_burst [3];
      exp_burst = WEN ? '{1'b1, 1'b1, 1'b0} : '{1'b0, 1'b1, 1'b0};

      step(); step();
      chk("rst_gnt",   32'(gnt),   32'd0);
      chk("rst_xadd",  32'(xadd),  32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_grp",   32'(grp),   32'd0);

      // Full rotation with weights 1/0 (0 behaves as 1).
      reset = 1'b0; enable = 1'b1; req = 8'hFF; weight = 16'h1111;
      for (int i = 0; i < 9; i++) begin
         wait_valid("rot_grant");
         chk("rot_xadd", 32'(xadd), 32'(i % 8));
         ack = 1'b1; step(); ack = 1'b0;
         chk("rot_drop", 32'(valid), 32'd0);
         chk("rot_grp",  32'(grp),   32'(i == 7));
      end
      req = '0; step();

      // Burst: row 2 weight 3.
      weight = 16'h1131; req = 8'h04;
      wait_valid("burst_grant");
      chk("burst_xadd", 32'(xadd), 32'd2);
      for (int k = 0; k < 3; k++) begin
         ack = 1'b1; step();
         chk("burst_valid", 32'(valid), 32'(exp_burst[k]));
      end
      ack = 1'b0; req = '0; step();

      // Withdrawal of row 3; next winner is the lowest row above 3.
      req = 8'h08;
      wait_valid("wd_grant");
      chk("wd_xadd", 32'(xadd), 32'd3);
      req = 8'h22; step();
      chk("wd_drop", 32'(valid), 32'd0);
      step();
      chk("wd_next_valid", 32'(valid), 32'd1);
      chk("wd_next_xadd",  32'(xadd),  32'd5);
      ack = 1'b1; step(); ack = 1'b0; req = '0; step();

      // Refresh during row 5 grant restores full priority.
      req = 8'h20;
      wait_valid("ref_grant");
      chk("ref_xadd", 32'(xadd), 32'd5);
      refresh = 1'b1; step(); refresh = 1'b0;
      chk("ref_held", 32'(valid), 32'd1);
      req = 8'h62; ack = 1'b1; step(); ack = 1'b0;
      chk("ref_drop", 32'(valid), 32'd0);
      req = 8'h42; step();
      chk("ref_next_valid", 32'(valid), 32'd1);
      chk("ref_next_xadd",  32'(xadd),  32'd1);
      ack = 1'b1; step(); ack = 1'b0; req = '0; step();

      // Reset in the middle of a held grant.
      weight = 16'h1131; req = 8'h04;
      wait_valid("rstb_grant");
      chk("rstb_xadd", 32'(xadd), 32'd2);
      ack = 1'b1; step(); ack = 1'b0; step();
      chk("rstb_held", 32'(valid), 32'd1);
      reset = 1'b1; step();
      chk("rstb_gnt",   32'(gnt),   32'd0);
      chk("rstb_valid", 32'(valid), 32'd0);
      chk("rstb_xadd0", 32'(xadd),  32'd0);
      chk("rstb_grp",   32'(grp),   32'd0);
      reset = 1'b0; req = 8'h81; step();
      chk("rstb_first", 32'(gnt), 32'h01);
      ack = 1'b1; step(); ack = 1'b0; req = '0; step();

      // enable_i gating.
      enable = 1'b0; req = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("en_off", 32'(valid), 32'd0);
      end
      enable = 1'b1; step();
      chk("en_on_valid", 32'(valid), 32'd1);
      chk("en_on_xadd",  32'(xadd),  32'd1);
      enable = 1'b0; ack = 1'b1; step(); ack = 1'b0;
      chk("en_drop", 32'(valid), 32'd0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("en_no_new", 32'(valid), 32'd0);
      end
      req = '0; step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
